// File: rtl/ncl_mult3_sched_if.sv
// Requester/consumer bus of the shared NCL multiplier controller.
// The controller sits on the slave side; the fabric drives the master side.
interface ncl_mult3_sched_if #(
  parameter int NREQ = 2
);
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [3*NREQ-1:0] req_a;
  logic [3*NREQ-1:0] req_b;
  logic              resp_valid;
  logic              resp_ready;
  logic [5:0]        resp_prod;
  logic [1:0]        resp_id;

  modport master (
    output req_valid, req_a, req_b, resp_ready,
    input  req_ready, resp_valid, resp_prod, resp_id
  );

  modport slave (
    input  req_valid, req_a, req_b, resp_ready,
    output req_ready, resp_valid, resp_prod, resp_id
  );
endinterface

// File: rtl/ncl_mult3_sched.sv
// Clocked front end for a shared 3x3 NCL dual-rail multiplier: round-robin
// arbitration, dual-rail encoding, DATA/NULL handshake and product return.
module ncl_mult3_sched #(
  parameter int NREQ           = 2,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic             clk,
  input  logic             rst,
  ncl_mult3_sched_if.slave bus,
  output logic [2:0]       mult_a_rail1,
  output logic [2:0]       mult_a_rail0,
  output logic [2:0]       mult_b_rail1,
  output logic [2:0]       mult_b_rail0,
  output logic             mult_ki,
  output logic             mult_rst,
  input  logic [5:0]       mult_p_rail1,
  input  logic [5:0]       mult_p_rail0,
  input  logic             mult_ko,
  output logic             err_timeout,
  output logic             err_illegal
);
  typedef enum logic [2:0] {
    RESET_HOLD, IDLE, WAIT_DATA, WAIT_NULL, RESP, RECOVER
  } state_t;

  localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);

  state_t      state_reg, state_next;
  logic [15:0] cnt_reg;
  logic [1:0]  ptr_reg, id_reg, win_idx;
  logic [2:0]  op_a_reg, op_b_reg, op_a_next, op_b_next, sel_a, sel_b, cand;
  logic [12:0] sync1_reg, sync2_reg;
  logic [11:0] rails_prev_reg;
  logic        null_prev_reg;
  logic [5:0]  prod_reg, p1_s, p0_s, dig_complete, dig_null, dig_illegal;
  logic        ko_s, all_data, null_now, all_null;
  logic        win_found, grant_any, ki_next, mrst_next, drive_data;
  logic [3:0]  valid_pad;
  logic [11:0] a_pad, b_pad;

  assign p1_s = sync2_reg[11:6];
  assign p0_s = sync2_reg[5:0];
  assign ko_s = sync2_reg[12];

  genvar gi;
  for (gi = 0; gi < 6; gi++) begin : g_digit
    assign dig_complete[gi] = p1_s[gi] ^ p0_s[gi];
    assign dig_null[gi]     = ~(p1_s[gi] | p0_s[gi]);
    assign dig_illegal[gi]  = p1_s[gi] & p0_s[gi];
  end

  // DATA must also be stable for a cycle so a skewed rail is never captured.
  assign all_data = (&dig_complete) && (sync2_reg[11:0] == rails_prev_reg);
  assign null_now = (&dig_null) && ko_s;
  assign all_null = null_now && null_prev_reg;

  // Rotating priority: search starts one past the last winner.
  always_comb begin
    valid_pad = 4'(bus.req_valid);
    win_found = 1'b0;
    win_idx   = ptr_reg;
    cand      = '0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = 3'(ptr_reg) + 3'(k);
      if (cand >= 3'(NREQ)) cand = cand - 3'(NREQ);
      if (!win_found && valid_pad[cand[1:0]]) begin
        win_found = 1'b1;
        win_idx   = cand[1:0];
      end
    end
  end

  assign a_pad     = 12'(bus.req_a);
  assign b_pad     = 12'(bus.req_b);
  assign sel_a     = a_pad[4'(win_idx) * 4'd3 +: 3];
  assign sel_b     = b_pad[4'(win_idx) * 4'd3 +: 3];
  assign grant_any = (state_reg == IDLE) && win_found && ko_s;
  assign op_a_next = grant_any ? sel_a : op_a_reg;
  assign op_b_next = grant_any ? sel_b : op_b_reg;

  for (gi = 0; gi < NREQ; gi++) begin : g_ready
    assign bus.req_ready[gi] = grant_any && (win_idx == 2'(gi));
  end

  assign bus.resp_valid = (state_reg == RESP);
  assign bus.resp_prod  = prod_reg;
  assign bus.resp_id    = id_reg;

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      RESET_HOLD: if (cnt_reg == 16'd1) state_next = IDLE;
      IDLE:       if (grant_any) state_next = WAIT_DATA;
      WAIT_DATA: begin
        if (all_data)                state_next = WAIT_NULL;
        else if (cnt_reg == TO_LAST) state_next = RECOVER;
      end
      WAIT_NULL: begin
        if (all_null)                state_next = RESP;
        else if (cnt_reg == TO_LAST) state_next = RECOVER;
      end
      RESP:       if (bus.resp_ready) state_next = IDLE;
      RECOVER:    state_next = RESET_HOLD;
      default:    state_next = RESET_HOLD;
    endcase
    // Multiplier-facing outputs are registered from the next state.
    ki_next    = (state_next == IDLE) || (state_next == WAIT_DATA);
    mrst_next  = (state_next == RESET_HOLD) || (state_next == RECOVER);
    drive_data = (state_next == WAIT_DATA);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg      <= RESET_HOLD;
      cnt_reg        <= '0;
      ptr_reg        <= 2'(NREQ - 1);
      id_reg         <= '0;
      op_a_reg       <= '0;
      op_b_reg       <= '0;
      prod_reg       <= '0;
      sync1_reg      <= '0;
      sync2_reg      <= '0;
      rails_prev_reg <= '0;
      null_prev_reg  <= 1'b0;
      mult_a_rail1   <= '0;
      mult_a_rail0   <= '0;
      mult_b_rail1   <= '0;
      mult_b_rail0   <= '0;
      mult_ki        <= 1'b0;
      mult_rst       <= 1'b1;
      err_timeout    <= 1'b0;
      err_illegal    <= 1'b0;
    end else begin
      state_reg      <= state_next;
      cnt_reg        <= (state_next != state_reg) ? 16'd0 : cnt_reg + 16'd1;
      sync1_reg      <= {mult_ko, mult_p_rail1, mult_p_rail0};
      sync2_reg      <= sync1_reg;
      rails_prev_reg <= sync2_reg[11:0];
      null_prev_reg  <= null_now;
      op_a_reg       <= op_a_next;
      op_b_reg       <= op_b_next;
      if (grant_any) begin
        id_reg  <= win_idx;
        ptr_reg <= win_idx;
      end
      if (state_reg == WAIT_DATA && all_data) prod_reg <= p1_s;
      mult_a_rail1 <= drive_data ? op_a_next  : 3'b000;
      mult_a_rail0 <= drive_data ? ~op_a_next : 3'b000;
      mult_b_rail1 <= drive_data ? op_b_next  : 3'b000;
      mult_b_rail0 <= drive_data ? ~op_b_next : 3'b000;
      mult_ki      <= ki_next;
      mult_rst     <= mrst_next;
      if (state_next == RECOVER) err_timeout <= 1'b1;
      if ((state_reg == WAIT_DATA || state_reg == WAIT_NULL) && (|dig_illegal))
        err_illegal <= 1'b1;
    end
  end
endmodule

// File: tb/tb_ncl_mult3_sched.sv
// Randomized scoreboard bench for ncl_mult3_sched with a behavioural
// zero-delay dual-rail multiplier that can be made to hang or go illegal.
module tb_ncl_mult3_sched;
  localparam int NREQ = 2;
  localparam int TO   = 40;

  typedef struct { int id; int prod; } exp_t;

  logic clk = 1'b0;
  logic rst;
  logic [2:0] a_r1, a_r0, b_r1, b_r0;
  logic ki, mrst, ko, err_to, err_il;
  logic [5:0] p_r1, p_r0, mprod;
  logic ops_data;

  ncl_mult3_sched_if #(.NREQ(NREQ)) bus ();

  ncl_mult3_sched #(.NREQ(NREQ), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .mult_a_rail1(a_r1), .mult_a_rail0(a_r0),
    .mult_b_rail1(b_r1), .mult_b_rail0(b_r0),
    .mult_ki(ki), .mult_rst(mrst),
    .mult_p_rail1(p_r1), .mult_p_rail0(p_r0), .mult_ko(ko),
    .err_timeout(err_to), .err_illegal(err_il)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0, cyc = 0;
  logic [2:0] op_a [NREQ];
  logic [2:0] op_b [NREQ];
  logic [2:0] fix_a [NREQ];
  logic [2:0] fix_b [NREQ];
  logic [NREQ-1:0] valid;
  logic resp_rdy;
  int ops_left [NREQ];
  bit rand_ops, rand_rr, hold_rr, drop_next, stuck_ko, illegal_d2;
  int model_ptr, grant_cyc, n_grants;
  exp_t sb[$];
  int gorder[$];
  exp_t mon_e;

  // Behavioural multiplier: product appears instantly once operands are DATA.
  assign ops_data = ((a_r1 ^ a_r0) == 3'b111) && ((b_r1 ^ b_r0) == 3'b111);
  assign mprod    = 6'(a_r1) * 6'(b_r1);
  always_comb begin
    p_r1 = '0;
    p_r0 = '0;
    ko   = 1'b1;
    if (!mrst && ops_data && ki) begin
      p_r1 = mprod;
      p_r0 = ~mprod;
      ko   = 1'b0;
      if (illegal_d2) begin
        p_r1[2] = 1'b1;
        p_r0[2] = 1'b1;
      end
    end
    if (stuck_ko) ko = 1'b0;
  end

  always_comb begin
    bus.req_valid = valid;
    bus.req_a = '0;
    bus.req_b = '0;
    for (int i = 0; i < NREQ; i++) begin
      bus.req_a[3*i +: 3] = op_a[i];
      bus.req_b[3*i +: 3] = op_b[i];
    end
  end
  assign bus.resp_ready = resp_rdy;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  task automatic new_op(input int i);
    valid[i] = 1'b1;
    op_a[i] = rand_ops ? 3'($urandom_range(0, 7)) : fix_a[i];
    op_b[i] = rand_ops ? 3'($urandom_range(0, 7)) : fix_b[i];
  endtask

  // One clock: observe grants at negedge, update stimulus after posedge.
  task automatic step();
    int w, g;
    logic [NREQ-1:0] gmask;
    exp_t e;
    @(negedge clk);
    gmask = '0;
    if (|bus.req_ready) begin
      w = -1;
      for (int k = 1; k <= NREQ; k++) begin
        int c = (model_ptr + k) % NREQ;
        if (w < 0 && valid[c]) w = c;
      end
      g = 0;
      for (int i = NREQ - 1; i >= 0; i--) if (bus.req_ready[i]) g = i;
      checks++;
      if (w < 0 || bus.req_ready != (NREQ'(1) << w)) begin
        errors++;
        $display("FAIL grant req_ready=%b valid=%b required_winner=%0d", bus.req_ready, valid, w);
      end
      if (drop_next) drop_next = 1'b0;
      else begin
        e.id = g;
        e.prod = int'(op_a[g]) * int'(op_b[g]);
        sb.push_back(e);
      end
      model_ptr = g;
      gmask[g] = 1'b1;
      grant_cyc = cyc + 1;
      n_grants++;
      gorder.push_back(g);
    end
    @(posedge clk);
    cyc++;
    #1;
    for (int i = 0; i < NREQ; i++) begin
      if (gmask[i]) begin
        if (ops_left[i] > 0) begin ops_left[i]--; new_op(i); end
        else valid[i] = 1'b0;
      end else if (rand_ops && valid[i] && $urandom_range(0, 7) == 0) begin
        valid[i] = 1'b0;
      end else if (rand_ops && !valid[i] && ops_left[i] > 0 && $urandom_range(0, 3) == 0) begin
        ops_left[i]--;
        new_op(i);
      end
    end
    resp_rdy = hold_rr ? 1'b0 : (rand_rr ? ($urandom_range(0, 3) != 0) : 1'b1);
  endtask

  function automatic bit busy();
    bit b = (valid != '0) || (sb.size() != 0);
    for (int i = 0; i < NREQ; i++) if (ops_left[i] > 0) b = 1'b1;
    return b;
  endfunction

  task automatic run_until_idle(input string name, input int budget);
    int n = 0;
    while (busy() && n < budget) begin step(); n++; end
    checks++;
    if (n >= budget) begin
      errors++;
      $display("FAIL %s still busy after %0d cycles, pending=%0d", name, n, sb.size());
    end
  endtask

  // Monitor: every accepted response is popped and compared.
  always @(negedge clk) begin
    if (!rst && bus.resp_valid && bus.resp_ready) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL resp_unexpected id=%0d prod=%0d required=none", bus.resp_id, bus.resp_prod);
      end else begin
        mon_e = sb.pop_front();
        if (bus.resp_prod != 6'(mon_e.prod) || bus.resp_id != 2'(mon_e.id)) begin
          errors++;
          $display("FAIL resp id=%0d prod=%0d required id=%0d prod=%0d",
                   bus.resp_id, bus.resp_prod, mon_e.id, mon_e.prod);
        end
      end
      checks++;
      if ({a_r1, a_r0, b_r1, b_r0} != 12'd0 || ki) begin
        errors++;
        $display("FAIL rails_null_in_resp rails=%h ki=%b required rails=0 ki=0",
                 {a_r1, a_r0, b_r1, b_r0}, ki);
      end
    end
    if (!rst && bus.resp_valid && |bus.req_ready) begin
      checks++;
      errors++;
      $display("FAIL ready_during_resp req_ready=%b required=0", bus.req_ready);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1);
  end

  task automatic check_reset_values(input string tag);
    chk({tag, "_req_ready"}, 32'(bus.req_ready), 0);
    chk({tag, "_resp_valid"}, 32'(bus.resp_valid), 0);
    chk({tag, "_resp_prod"}, 32'(bus.resp_prod), 0);
    chk({tag, "_resp_id"}, 32'(bus.resp_id), 0);
    chk({tag, "_rails"}, 32'({a_r1, a_r0, b_r1, b_r0}), 0);
    chk({tag, "_ki"}, 32'(ki), 0);
    chk({tag, "_mult_rst"}, 32'(mrst), 1);
    chk({tag, "_err_timeout"}, 32'(err_to), 0);
    chk({tag, "_err_illegal"}, 32'(err_il), 0);
  endtask

  initial begin
    int n, t0, g0;
    logic [7:0] cap;
    bit alt;
    rst = 1'b1; valid = '0; resp_rdy = 1'b1;
    rand_ops = 0; rand_rr = 0; hold_rr = 0; drop_next = 0; stuck_ko = 0; illegal_d2 = 0;
    model_ptr = NREQ - 1; n_grants = 0; grant_cyc = 0;
    for (int i = 0; i < NREQ; i++) begin
      op_a[i] = '0; op_b[i] = '0; fix_a[i] = '0; fix_b[i] = '0; ops_left[i] = 0;
    end
    repeat (3) @(posedge clk);
    #1;
    check_reset_values("reset");
    rst = 1'b0;
    step();
    chk("hold1_mult_rst", 32'(mrst), 1);
    chk("hold1_ki", 32'(ki), 0);
    step();
    chk("hold2_mult_rst", 32'(mrst), 0);
    chk("hold2_ki", 32'(ki), 1);

    // 7*7 on requester 0, latency with a zero-delay multiplier
    fix_a[0] = 3'd7; fix_b[0] = 3'd7; new_op(0);
    n = 0;
    while (!bus.resp_valid && n < 60) begin step(); n++; end
    chk("latency", 32'(cyc - grant_cyc), 8);
    run_until_idle("mul77", 50);
    chk("mul77_err", 32'({err_to, err_il}), 0);

    // both requesters continuously valid: grants must alternate
    gorder.delete();
    fix_a[0] = 3'd3; fix_b[0] = 3'd5; fix_a[1] = 3'd2; fix_b[1] = 3'd6;
    ops_left[0] = 3; ops_left[1] = 3;
    new_op(0); new_op(1);
    run_until_idle("alternate", 200);
    alt = (gorder.size() == 8);
    for (int k = 1; k < gorder.size(); k++) if (gorder[k] == gorder[k-1]) alt = 1'b0;
    chk("alternate_order", 32'(alt), 1);

    // zero operands; rails must be NULL between operations
    fix_a[0] = 3'd0; fix_b[0] = 3'd5; new_op(0);
    run_until_idle("zero_a", 50);
    chk("rails_idle_1", 32'({a_r1, a_r0, b_r1, b_r0}), 0);
    fix_a[0] = 3'd5; fix_b[0] = 3'd0; new_op(0);
    run_until_idle("zero_b", 50);
    chk("rails_idle_2", 32'({a_r1, a_r0, b_r1, b_r0}), 0);

    // consumer stall for 20 cycles with the other requester waiting
    hold_rr = 1; resp_rdy = 1'b0;
    fix_a[0] = 3'd6; fix_b[0] = 3'd3; fix_a[1] = 3'd1; fix_b[1] = 3'd4;
    new_op(0); new_op(1);
    n = 0;
    while (!bus.resp_valid && n < 40) begin step(); n++; end
    cap = {bus.resp_prod, bus.resp_id};
    for (int k = 0; k < 20; k++) begin
      step();
      chk("stall_hold", 32'({bus.resp_valid, bus.resp_prod, bus.resp_id}), 32'({1'b1, cap}));
    end
    hold_rr = 0;
    run_until_idle("stall_release", 100);

    // randomized traffic with random consumer backpressure
    rand_ops = 1; rand_rr = 1;
    ops_left[0] = 15; ops_left[1] = 15;
    new_op(0); new_op(1);
    run_until_idle("random", 3000);
    rand_ops = 0; rand_rr = 0;
    chk("random_err", 32'({err_to, err_il}), 0);

    // multiplier never returns Ko after DATA: timeout and recovery
    drop_next = 1;
    fix_a[0] = 3'd3; fix_b[0] = 3'd3; new_op(0);
    g0 = n_grants; n = 0;
    while (n_grants == g0 && n < 20) begin step(); n++; end
    stuck_ko = 1;
    n = 0;
    while (ki && n < 30) begin step(); n++; end
    t0 = cyc; n = 0;
    while (!err_to && n < TO + 20) begin step(); n++; end
    chk("timeout_delay", 32'(cyc - t0), TO);
    chk("timeout_mult_rst", 32'(mrst), 1);
    stuck_ko = 0;
    n = 0;
    while (mrst && n < 10) begin step(); n++; end
    chk("timeout_rst_release", 32'(mrst), 0);
    fix_a[0] = 3'd4; fix_b[0] = 3'd5; new_op(0);
    run_until_idle("after_timeout", 60);
    chk("timeout_sticky", 32'(err_to), 1);
    chk("no_illegal_yet", 32'(err_il), 0);

    // both rails of digit 2 high: illegal flag, then reset mid WAIT_DATA
    illegal_d2 = 1; drop_next = 1;
    fix_a[0] = 3'd7; fix_b[0] = 3'd5; new_op(0);
    n = 0;
    while (!err_il && n < 20) begin step(); n++; end
    chk("illegal_set", 32'(err_il), 1);
    repeat (3) step();
    chk("illegal_sticky", 32'(err_il), 1);
    chk("illegal_still_waiting", 32'(ki), 1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_reset_values("midrst");
    valid = '0; illegal_d2 = 0; drop_next = 0; model_ptr = NREQ - 1;
    sb.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    step(); step();
    fix_a[1] = 3'd2; fix_b[1] = 3'd7; new_op(1);
    run_until_idle("after_reset", 60);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
